fsgn_exec_stage: RTL and testbench
==================================

// Module: fsgn_exec_stage
// PURPOSE
//   FPU sign-injection execute stage: FSGNJ/FSGNJN/FSGNJX for double and
//   NaN-boxed single. Sits between FP issue (operand read) and FP writeback.
//   Computes the result, then buffers it in a 2-entry output queue, so issue
//   sees a ready signal that depends only on registered state.
// PARAMETERS
//   BUS_WIDTH  64  operand/result width; fixed at 64, single is NaN-boxed
//   TAG_WIDTH  5   destination register tag carried alongside the result
// PORTS
//   clk         in   1          clock, rising edge
//   rst_n       in   1          async active-low reset
//   flush       in   1          sync pipeline flush; drops all buffered entries
//   in_valid    in   1          issue presents an operation
//   in_ready    out  1          stage can accept an operation this cycle
//   in_op       in   2          00=FSGNJ 01=FSGNJN 10=FSGNJX 11=reserved (acts as FSGNJ)
//   in_fmt      in   1          0=double, 1=single (NaN-boxed)
//   in_rs1      in   BUS_WIDTH  magnitude source
//   in_rs2      in   BUS_WIDTH  sign source
//   in_rd       in   TAG_WIDTH  destination tag
//   out_valid   out  1          result available at head of queue
//   out_ready   in   1          writeback consumes head
//   out_result  out  BUS_WIDTH  head result
//   out_rd      out  TAG_WIDTH  head tag
// BEHAVIOUR
//   Arithmetic (combinational on the accepted inputs):
//   - Double: s1=rs1[63], s2=rs2[63]. Sign-bit mapping:
//       J   -> s2
//       JN  -> ~s2
//       JX  -> s1^s2
//     result = {sign, rs1[62:0]}.
//   - Single: an operand whose rs[63:32] != 32'hFFFFFFFF is replaced by
//     canonical NaN 32'h7FC00000. Then s1=op1[31], s2=op2[31], and the same
//     sign-bit mapping applies. result = {32'hFFFFFFFF, sign, op1[30:0]}.
//   - NaN sign source, all ops: if op2 is NaN (exp all ones, mantissa != 0),
//     sign is not injected.
//       Double: result = rs1 unchanged.
//       Single: result = {32'hFFFFFFFF, op1}.
//     This matches the existing FSGNJ unit.
//   Handshake / queue:
//   - Accept when in_valid && in_ready; the computed result and in_rd are
//     written to the queue tail.
//   - Queue is 2 entries: count register 0..2. in_ready = (count != 2);
//     depends only on registers.
//   - out_valid = (count != 0). out_result/out_rd show the head entry and
//     are held stable while out_valid && !out_ready.
//   - Pop when out_valid && out_ready; next entry moves to head the
//     following cycle.
//   - Simultaneous push and pop:
//       count=1 -> count stays 1, new entry becomes head.
//       count=2 -> push not possible (in_ready=0); pop only.
//   - Latency 1: accepted at edge N -> out_valid high after edge N, with no
//     combinational in->out path. Throughput 1 op/cycle when out_ready is
//     held high.
//   - Order preserved (FIFO); no drops, no duplication.
//   - flush: at the next edge count=0 and out_valid=0. An input presented
//     in the flush cycle is discarded even if in_valid && in_ready.
//     flush wins over push and pop.
//   Reset (async, rst_n=0): count=0, out_valid=0, in_ready=1, out_result=0,
//   out_rd=0, all queue storage = 0. Reset mid-operation discards all
//   entries. The first accept is possible on the first edge after rst_n
//   deasserts.
// TESTING
//   1. Double J: rs1=3FF0000000000000 rs2=C000000000000000 op=00
//      -> out_result BFF0000000000000, out_valid one cycle after accept.
//   2. Double JN/JX: rs1=BFF0000000000000 rs2=C000000000000000
//      -> JN 3FF0000000000000; JX 3FF0000000000000.
//   3. NaN sign source: rs1=4008000000000000 rs2=FFF8000000000000, each op
//      -> 4008000000000000.
//   4. Single: rs1=FFFFFFFF3F800000 rs2=FFFFFFFFC0000000 J -> FFFFFFFFBF800000.
//      rs1=000000003F800000 (not boxed), J, rs2 positive -> FFFFFFFF7FC00000.
//   5. Backpressure: hold out_ready=0 and push 3 ops -> first two accepted,
//      in_ready=0 on the third. Release out_ready -> results drain in order
//      with tags intact.
//   6. flush with count=2, and rst_n pulse mid-stream -> out_valid=0 next
//      edge (immediately for reset), in_ready=1, no stale result emitted.

Source files
------------

// File: rtl/fsgn_exec_stage.sv
// ----------------------------------------------------------------------------
// fsgn_exec_stage
//   FPU sign-injection execute stage (FSGNJ / FSGNJN / FSGNJX) for double
//   precision and NaN-boxed single precision. The result is computed
//   combinationally from the issued operands and written into a 2-entry
//   output queue. Because in_ready is derived only from the queue occupancy
//   register, issue never sees a combinational path from writeback.
//
//   Ports
//     clk, rst_n            rising-edge clock, async active-low reset
//     flush                 synchronous flush, drops every buffered entry
//     in_valid / in_ready   issue handshake
//     in_op                 00=J 01=JN 10=JX 11=J
//     in_fmt                0=double, 1=single (NaN-boxed)
//     in_rs1 / in_rs2       magnitude source / sign source
//     in_rd                 destination tag carried with the result
//     out_valid / out_ready writeback handshake
//     out_result / out_rd   head-of-queue result and tag
// ----------------------------------------------------------------------------
module fsgn_exec_stage #(
    parameter int BUS_WIDTH = 64,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic                 in_fmt,
    input  logic [BUS_WIDTH-1:0] in_rs1,
    input  logic [BUS_WIDTH-1:0] in_rs2,
    input  logic [TAG_WIDTH-1:0] in_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0] out_rd
);

    localparam logic [31:0] NAN_BOX   = 32'hFFFF_FFFF;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    logic [31:0]          sp_op1;
    logic [31:0]          sp_op2;
    logic                 sign_a;
    logic                 sign_b;
    logic                 sign_new;
    logic                 sign_src_nan;
    logic [BUS_WIDTH-1:0] calc_result;

    logic [1:0]           count;
    logic [BUS_WIDTH-1:0] slot0_result;
    logic [BUS_WIDTH-1:0] slot1_result;
    logic [TAG_WIDTH-1:0] slot0_rd;
    logic [TAG_WIDTH-1:0] slot1_rd;
    logic                 push;
    logic                 pop;

    // Sign-injection datapath. Single operands that are not properly
    // NaN-boxed are treated as the canonical NaN before anything else, so an
    // unboxed sign source also counts as a NaN and suppresses injection.
    // When the sign source is a NaN the magnitude operand passes unchanged.
    always_comb begin
        sp_op1       = (in_rs1[63:32] == NAN_BOX) ? in_rs1[31:0] : CANON_NAN;
        sp_op2       = (in_rs2[63:32] == NAN_BOX) ? in_rs2[31:0] : CANON_NAN;
        sign_a       = 1'b0;
        sign_b       = 1'b0;
        sign_src_nan = 1'b0;
        calc_result  = '0;

        if (in_fmt) begin
            sign_a       = sp_op1[31];
            sign_b       = sp_op2[31];
            sign_src_nan = (sp_op2[30:23] == 8'hFF) && (sp_op2[22:0] != 23'd0);
        end else begin
            sign_a       = in_rs1[63];
            sign_b       = in_rs2[63];
            sign_src_nan = (in_rs2[62:52] == 11'h7FF) && (in_rs2[51:0] != 52'd0);
        end

        case (in_op)
            2'b01:   sign_new = ~sign_b;
            2'b10:   sign_new = sign_a ^ sign_b;
            default: sign_new = sign_b;
        endcase

        if (in_fmt) begin
            if (sign_src_nan) begin
                calc_result = {NAN_BOX, sp_op1};
            end else begin
                calc_result = {NAN_BOX, sign_new, sp_op1[30:0]};
            end
        end else begin
            if (sign_src_nan) begin
                calc_result = in_rs1;
            end else begin
                calc_result = {sign_new, in_rs1[62:0]};
            end
        end
    end

    // Handshake decode. Flush suppresses both push and pop so the queue
    // simply empties at the next edge.
    always_comb begin
        in_ready   = (count != 2'd2);
        out_valid  = (count != 2'd0);
        out_result = slot0_result;
        out_rd     = slot0_rd;
        push       = in_valid && in_ready && !flush;
        pop        = out_valid && out_ready && !flush;
    end

    // Two-slot queue: slot0 is always the head. A push into an empty queue,
    // or a push that coincides with popping the only entry, lands in slot0;
    // otherwise it lands in slot1. A lone pop shifts slot1 forward. Push and
    // pop together can only happen with one entry, since a full queue
    // refuses the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= 2'd0;
            slot0_result <= '0;
            slot1_result <= '0;
            slot0_rd     <= '0;
            slot1_rd     <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0_result <= calc_result;
                        slot0_rd     <= in_rd;
                    end else begin
                        slot1_result <= calc_result;
                        slot1_rd     <= in_rd;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0_result <= slot1_result;
                    slot0_rd     <= slot1_rd;
                    count        <= count - 2'd1;
                end
                2'b11: begin
                    slot0_result <= calc_result;
                    slot0_rd     <= in_rd;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsgn_exec_stage.sv
// ----------------------------------------------------------------------------
// tb_fsgn_exec_stage
//   Self-checking bench for fsgn_exec_stage. A behavioural model (a queue of
//   expected {tag, result} pairs plus a function computing the sign-injection
//   result from the arithmetic rules) is compared with the DUT outputs on
//   every falling clock edge. Directed cases pin the model and the DUT to
//   hand-computed values; a randomized phase with flushes and a mid-stream
//   reset follows.
// ----------------------------------------------------------------------------
module tb_fsgn_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_fmt;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;

    int checks   = 0;
    int failures = 0;

    logic [68:0] model_q[$];

    fsgn_exec_stage #(.BUS_WIDTH(64), .TAG_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_fmt     (in_fmt),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    // 10 ns clock; rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic written straight from the sign-injection rules.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic fmt,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        if (!fmt) begin
            if (b[62:52] == 11'h7FF && b[51:0] != 0) return a;
            s = (op == 2'd1) ? !b[63] : (op == 2'd2) ? (a[63] != b[63]) : b[63];
            return {s, a[62:0]};
        end
        x = (a[63:32] == 32'hFFFFFFFF) ? a[31:0] : 32'h7FC00000;
        y = (b[63:32] == 32'hFFFFFFFF) ? b[31:0] : 32'h7FC00000;
        if (y[30:23] == 8'hFF && y[22:0] != 0) return {32'hFFFFFFFF, x};
        s = (op == 2'd1) ? !y[31] : (op == 2'd2) ? (x[31] != y[31]) : y[31];
        return {32'hFFFFFFFF, s, x[30:0]};
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        case ($urandom_range(0, 3))
            0:       return {r1, r2};
            1:       return {32'hFFFFFFFF, r2};
            2:       return {32'hFFFFFFFF, r1[31], 8'hFF, r2[22:0] | 23'h1};
            default: return {r1[31], 11'h7FF, r1[19:0], r2 | 32'h1};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one operation at a falling edge and hold it until the next one.
    task automatic applyStimulus(input logic [1:0] op, input logic fmt,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] rd);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_fmt   = fmt;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drainQueue();
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Model update: clear on reset or flush, otherwise pop the head and
    // append the newly accepted operation, in that order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            logic        acc;
            logic [68:0] entry;
            acc   = in_valid && (model_q.size() < 2);
            entry = {in_rd, ref_calc(in_op, in_fmt, in_rs1, in_rs2)};
            if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (acc) model_q.push_back(entry);
        end
    end

    // Per-cycle compare of handshake and head entry against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
            if (model_q.size() > 0) begin
                checkOutput("out_result", out_result, model_q[0][63:0]);
                checkOutput("out_rd", {59'd0, out_rd}, {59'd0, model_q[0][68:64]});
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_fmt    = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        out_ready = 1'b0;

        #1;
        checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_result", out_result, 64'd0);
        checkOutput("rst_rd", {59'd0, out_rd}, 64'd0);
        #11 rst_n = 1'b1;

        // Hand-computed pins on the reference function itself.
        checkOutput("pin_j", ref_calc(2'd0, 1'b0, 64'h3FF0000000000000, 64'hC000000000000000), 64'hBFF0000000000000);
        checkOutput("pin_jn", ref_calc(2'd1, 1'b0, 64'hBFF0000000000000, 64'hC000000000000000), 64'h3FF0000000000000);
        checkOutput("pin_jx", ref_calc(2'd2, 1'b0, 64'hBFF0000000000000, 64'hC000000000000000), 64'h3FF0000000000000);
        checkOutput("pin_nan", ref_calc(2'd1, 1'b0, 64'h4008000000000000, 64'hFFF8000000000000), 64'h4008000000000000);
        checkOutput("pin_sgl", ref_calc(2'd0, 1'b1, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFC0000000), 64'hFFFFFFFFBF800000);
        checkOutput("pin_unbox", ref_calc(2'd0, 1'b1, 64'h000000003F800000, 64'hFFFFFFFF40000000), 64'hFFFFFFFF7FC00000);

        // Directed DUT cases: each result visible one cycle after accept.
        applyStimulus(2'd0, 1'b0, 64'h3FF0000000000000, 64'hC000000000000000, 5'd1);
        #1 checkOutput("t1_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("t1_result", out_result, 64'hBFF0000000000000);
        drainQueue();
        applyStimulus(2'd1, 1'b0, 64'hBFF0000000000000, 64'hC000000000000000, 5'd2);
        #1 checkOutput("t2_jn", out_result, 64'h3FF0000000000000);
        drainQueue();
        applyStimulus(2'd2, 1'b0, 64'hBFF0000000000000, 64'hC000000000000000, 5'd3);
        #1 checkOutput("t2_jx", out_result, 64'h3FF0000000000000);
        drainQueue();
        for (int op = 0; op < 4; op++) begin
            applyStimulus(op[1:0], 1'b0, 64'h4008000000000000, 64'hFFF8000000000000, 5'd4);
            #1 checkOutput("t3_nan", out_result, 64'h4008000000000000);
            drainQueue();
        end
        applyStimulus(2'd0, 1'b1, 64'hFFFFFFFF3F800000, 64'hFFFFFFFFC0000000, 5'd5);
        #1 checkOutput("t4_single", out_result, 64'hFFFFFFFFBF800000);
        drainQueue();
        applyStimulus(2'd0, 1'b1, 64'h000000003F800000, 64'hFFFFFFFF40000000, 5'd6);
        #1 checkOutput("t4_unboxed", out_result, 64'hFFFFFFFF7FC00000);
        drainQueue();

        // Backpressure: three pushes with out_ready low, third refused.
        @(negedge clk);
        in_valid = 1'b1;
        in_fmt   = 1'b0;
        in_op    = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in_rs1 = 64'h4000000000000000 + i;
            in_rs2 = 64'h8000000000000000;
            in_rd  = 5'd10 + i[4:0];
            @(negedge clk);
        end
        #1 checkOutput("t5_full", {63'd0, in_ready}, 64'd0);
        checkOutput("t5_head_rd", {59'd0, out_rd}, 64'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1 checkOutput("t5_second_rd", {59'd0, out_rd}, 64'd11);
        checkOutput("t5_second_res", out_result, 64'hC000000000000001);
        @(negedge clk);
        #1 checkOutput("t5_empty", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;

        // Flush with a full queue while an input is also offered.
        applyStimulus(2'd0, 1'b0, 64'h1, 64'h2, 5'd20);
        applyStimulus(2'd0, 1'b0, 64'h3, 64'h4, 5'd21);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 checkOutput("t6_flush_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("t6_flush_ready", {63'd0, in_ready}, 64'd1);

        // Randomized traffic with occasional flushes and one reset pulse.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_fmt    = 1'($urandom_range(0, 1));
            in_rs1    = rand_operand();
            in_rs2    = rand_operand();
            in_rd     = 5'($urandom_range(0, 31));
            if (cyc == 1500) begin
                #2 rst_n = 1'b0;
                #1 checkOutput("rst_mid_valid", {63'd0, out_valid}, 64'd0);
                checkOutput("rst_mid_ready", {63'd0, in_ready}, 64'd1);
                checkOutput("rst_mid_result", out_result, 64'd0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
